present_key_sched: RTL
======================

# present_key_sched

Parametrised PRESENT key-schedule unit that generates the PRESENT round keys for 80- or 128-bit master keys. It holds the master key and steps a working key register through the full schedule, one round per request. It precomputes the final round key, the copy the decryption datapath needs first. It sits beside the PRESENT round datapath and feeds it one 64-bit round key per round.

## Interface
- KEY_W, 80, master key width; legal values 80 or 128, any other value is an elaboration error
- ROUNDS, 31, number of schedule updates; the unit produces round keys K1..K(ROUNDS+1)
- inClk  input  1  clock; all logic on the rising edge
- inRst  input  1  reset; synchronous, active-high
- inKeyLoad  input  1  load strobe for the master key
- inKeyData  input  KEY_W  master key, sampled when inKeyLoad=1
- inNext  input  1  advance to the next round key
- inRewind  input  1  restart the sequence from the first key of the current direction
- inDir  input  1  direction, sampled at rewind; 0 = encrypt order; 1 = decrypt order (only with PRESENT_KEY_DEC_EN)
- outBusy  output  1  high during precompute
- outReady  output  1  high when outRoundKey is valid
- outDone  output  1  high when the last key of the sequence is presented
- outRoundIdx  output  6  index of the presented key, 1..ROUNDS+1
- outRoundKey  output  64  current round key, working[KEY_W-1:KEY_W-64]
- outLastKey  output  64  K(ROUNDS+1), valid while outReady=1

## Operation
- States: IDLE, PREP, READY, DONE.
- Forward update, 80-bit key:
  - rotate the key left by 61;
  - apply the S-box to [79:76];
  - XOR the 5-bit counter into [19:15].
- Forward update, 128-bit key:
  - rotate the key left by 61;
  - apply the S-box to [127:124] and to [123:120];
  - XOR the counter into [66:62].
- Inverse update:
  - XOR the counter back out;
  - apply the inverse S-box to the same nibbles;
  - rotate right by 61.
- IDLE: outputs hold at zero. inNext and inRewind are ignored.
- inKeyLoad, accepted in any state:
  - master <= inKeyData, working <= inKeyData, counter <= 1;
  - go to PREP.
- PREP: one forward update per cycle, counter incrementing, for ROUNDS cycles. Then:
  - lastFull <= updated working key;
  - working <= master, idx <= 1;
  - go to READY.
- READY, on inNext:
  - working <= forward update, idx++;
  - when idx reaches ROUNDS+1, go to DONE.
- DONE: inNext ignored. outDone=1.
- inRewind in READY or DONE:
  - working <= master, idx <= 1;
  - go to READY.
- Priority: inRst > inKeyLoad > inRewind > inNext.
- Reset mid-PREP: the unit returns to IDLE and the master key is lost.
- A load during PREP restarts the precompute.
- Counter arithmetic is 5-bit and never wraps; its largest value is 31.

## Timing
- Reset values: all registers 0, state IDLE; every output 0, including outRoundKey, outLastKey and outRoundIdx.
- Load at edge t:
  - outBusy=1 from t+1 through t+ROUNDS;
  - outReady=1 and outLastKey valid from t+ROUNDS+1;
  - outRoundKey=K1 at t+ROUNDS+1.
- inNext at edge t: the next key appears after edge t, i.e. one-cycle latency.
- A new key is available every cycle when inNext is held high.
- inRewind: K1 (or K(ROUNDS+1) in decrypt order) is presented after the edge.
- outReady drops to 0 one cycle after any load and stays low through PREP.

## Configuration
- PRESENT_KEY_DEC_EN defined: inDir is honoured at rewind and at the end of PREP.
  - Decrypt order: working <= lastFull, idx <= ROUNDS+1, counter <= ROUNDS.
  - Each inNext applies the inverse update, decrementing idx and counter.
  - DONE is reached at idx=1.
- PRESENT_KEY_DEC_EN undefined:
  - inDir is ignored and the inverse S-box logic is not built;
  - encrypt order only;
  - outLastKey is still produced.

## Structure
- Package present_pkg:
  - S-box and inverse S-box functions;
  - ROUNDS_DEFAULT=31;
  - key-width constants 80 and 128;
  - state enum.
- Sub-module present_key_update: combinational single-step update, parametrised by KEY_W.
  - Inputs: key, counter, inverse-select.
  - Output: next key.
  - Instantiated once. PREP and READY share it, and it is selected by state.

## Test plan
- KEY_W=80, load 0x0, wait 32 cycles: outReady=1, outRoundKey=0x0000000000000000, outRoundIdx=1; one inNext gives 0xC000000000000000.
- KEY_W=80, load all-ones: after one inNext, K2=0x2FFFFFFFFFFFFFFF. Step 30 more times: outDone=1, idx=32, outRoundKey equals outLastKey and the golden model; a further inNext changes nothing.
- KEY_W=128, load 0x0: K2=0xCC00000000000000; all 32 keys match the golden model.
- Load asserted at PREP cycle 10, then inRst at PREP cycle 5 of a new load: the restarted PREP yields the new key's K1; the reset yields all outputs 0 and IDLE.
- Simultaneous inNext+inRewind in READY at idx=7 gives idx=1 and K1. inKeyLoad+inNext together gives PREP.
- With PRESENT_KEY_DEC_EN, inDir=1 and inRewind: keys appear K32..K1, bit-exact to the reversed encrypt sequence, and outDone is asserted at idx=1.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT key schedule: S-boxes, width constants and FSM states.
package present_pkg;

  localparam int ROUNDS_DEFAULT = 31;
  localparam int KEY_W_80       = 80;
  localparam int KEY_W_128      = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } ks_state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_update.sv
// One combinational PRESENT key-schedule step (forward, or inverse when PRESENT_KEY_DEC_EN is defined).
module present_key_update
  import present_pkg::*;
#(
  parameter int KEY_W = KEY_W_80
) (
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       counter,
  input  logic             inv,
  output logic [KEY_W-1:0] next_key
);

  logic [KEY_W-1:0] fwd_s;

  if (KEY_W != KEY_W_80 && KEY_W != KEY_W_128) begin : g_bad_width
    $error("present_key_update: KEY_W must be 80 or 128");
  end

  // Forward step: rotate left 61, S-box the top nibble(s), fold in the round counter.
  always_comb begin
    fwd_s = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};
    fwd_s[KEY_W-1 -: 4] = sbox(fwd_s[KEY_W-1 -: 4]);
    if (KEY_W == KEY_W_128) begin
      fwd_s[KEY_W-5 -: 4] = sbox(fwd_s[KEY_W-5 -: 4]);
      fwd_s[66:62] = fwd_s[66:62] ^ counter;
    end else begin
      fwd_s[19:15] = fwd_s[19:15] ^ counter;
    end
  end

`ifdef PRESENT_KEY_DEC_EN
  logic [KEY_W-1:0] pre_s;
  logic [KEY_W-1:0] inv_s;

  // Inverse step undoes the forward operations in reverse order.
  always_comb begin
    pre_s = key;
    if (KEY_W == KEY_W_128) begin
      pre_s[66:62] = pre_s[66:62] ^ counter;
      pre_s[KEY_W-5 -: 4] = inv_sbox(pre_s[KEY_W-5 -: 4]);
    end else begin
      pre_s[19:15] = pre_s[19:15] ^ counter;
    end
    pre_s[KEY_W-1 -: 4] = inv_sbox(pre_s[KEY_W-1 -: 4]);
    inv_s = {pre_s[60:0], pre_s[KEY_W-1:61]};
  end

  assign next_key = inv ? inv_s : fwd_s;
`else
  logic unused_inv_s;
  assign unused_inv_s = inv;
  assign next_key     = fwd_s;
`endif

endmodule

// File: rtl/present_key_sched.sv
// PRESENT round-key sequencer: precomputes the last round key, then steps K1..K(ROUNDS+1).
// Define PRESENT_KEY_DEC_EN to add the decrypt (reverse) order selected by inDir.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_W  = KEY_W_80,
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inKeyLoad,
  input  logic [KEY_W-1:0] inKeyData,
  input  logic             inNext,
  input  logic             inRewind,
  input  logic             inDir,
  output logic             outBusy,
  output logic             outReady,
  output logic             outDone,
  output logic [5:0]       outRoundIdx,
  output logic [63:0]      outRoundKey,
  output logic [63:0]      outLastKey
);

`ifdef PRESENT_KEY_DEC_EN
  localparam int LAST_W = KEY_W;
`else
  localparam int LAST_W = 64;
`endif
  localparam logic [4:0] CNT_LAST = 5'(ROUNDS);
  localparam logic [5:0] IDX_LAST = 6'(ROUNDS + 1);

  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_key_sched: ROUNDS must be 1..31");
  end

  ks_state_e         state_r, state_n;
  logic [KEY_W-1:0]  master_r, master_n;
  logic [KEY_W-1:0]  working_r, working_n;
  logic [4:0]        counter_r, counter_n;
  logic [5:0]        idx_r, idx_n;
  logic [LAST_W-1:0] last_r, last_n;
  logic              busy_r, ready_r, done_r;

  logic [KEY_W-1:0]  upd_s;
  logic              start_s;
  logic              dir_s;
  logic              seq_dec_s;
  logic [KEY_W-1:0]  seq_key_s;
  logic [5:0]        seq_idx_s;
  logic [4:0]        seq_cnt_s;
  logic [5:0]        step_idx_s;
  logic [4:0]        step_cnt_s;
  logic              step_end_s;

`ifdef PRESENT_KEY_DEC_EN
  logic dir_r;

  // Direction is latched whenever a sequence (re)starts.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      dir_r <= 1'b0;
    end else if (start_s) begin
      dir_r <= seq_dec_s;
    end else begin
      dir_r <= dir_r;
    end
  end

  assign dir_s     = dir_r;
  assign seq_dec_s = inDir;
  // At the end of PREP the final key is still on the update output, not yet in last_r.
  assign seq_key_s = seq_dec_s ? ((state_r == PREP) ? upd_s : last_r) : master_r;
`else
  logic unused_dir_s;
  assign unused_dir_s = inDir;
  assign dir_s        = 1'b0;
  assign seq_dec_s    = 1'b0;
  assign seq_key_s    = master_r;
`endif

  assign start_s = !inKeyLoad &&
                   (((state_r == PREP) && (counter_r == CNT_LAST)) ||
                    (((state_r == READY) || (state_r == DONE)) && inRewind));

  assign seq_idx_s  = seq_dec_s ? IDX_LAST : 6'd1;
  assign seq_cnt_s  = seq_dec_s ? CNT_LAST : 5'd1;
  assign step_idx_s = dir_s ? (idx_r - 6'd1) : (idx_r + 6'd1);
  assign step_end_s = dir_s ? (idx_r == 6'd2) : (idx_r == (IDX_LAST - 6'd1));
  // Counter holds on the final step so it never leaves 1..ROUNDS.
  assign step_cnt_s = step_end_s ? counter_r : (dir_s ? (counter_r - 5'd1) : (counter_r + 5'd1));

  present_key_update #(.KEY_W(KEY_W)) u_update (
    .key      (working_r),
    .counter  (counter_r),
    .inv      ((state_r == READY) && dir_s),
    .next_key (upd_s)
  );

  // Next-state and datapath decode; priority is load > rewind/PREP end > next.
  always_comb begin
    state_n   = state_r;
    master_n  = master_r;
    working_n = working_r;
    counter_n = counter_r;
    idx_n     = idx_r;
    last_n    = last_r;
    if (inKeyLoad) begin
      master_n  = inKeyData;
      working_n = inKeyData;
      counter_n = 5'd1;
      idx_n     = 6'd0;
      state_n   = PREP;
    end else if (start_s) begin
      working_n = seq_key_s;
      idx_n     = seq_idx_s;
      counter_n = seq_cnt_s;
      state_n   = READY;
      if (state_r == PREP) begin
        last_n = upd_s[KEY_W-1 -: LAST_W];
      end else begin
        last_n = last_r;
      end
    end else begin
      case (state_r)
        PREP: begin
          working_n = upd_s;
          counter_n = counter_r + 5'd1;
        end
        READY: begin
          if (inNext) begin
            working_n = upd_s;
            idx_n     = step_idx_s;
            counter_n = step_cnt_s;
            state_n   = step_end_s ? DONE : READY;
          end else begin
            state_n = READY;
          end
        end
        IDLE:    state_n = IDLE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Key/counter datapath and registered status flags.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      master_r  <= '0;
      working_r <= '0;
      counter_r <= 5'd0;
      idx_r     <= 6'd0;
      last_r    <= '0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      master_r  <= master_n;
      working_r <= working_n;
      counter_r <= counter_n;
      idx_r     <= idx_n;
      last_r    <= last_n;
      busy_r    <= (state_n == PREP);
      ready_r   <= (state_n == READY) || (state_n == DONE);
      done_r    <= (state_n == DONE);
    end
  end

  assign outBusy     = busy_r;
  assign outReady    = ready_r;
  assign outDone     = done_r;
  assign outRoundIdx = idx_r;
  assign outRoundKey = working_r[KEY_W-1 -: 64];
  assign outLastKey  = last_r[LAST_W-1 -: 64];

endmodule
